// File: rtl/cnot_gate_scheduler.sv
// ---------------------------------------------------------------------------
// cnot_gate_scheduler
//
// Purpose
//   Shares a single external 1-bit controlled-NOT gate (y = en ? !a : a)
//   between two requesters. A granted W-bit data word and its W-bit control
//   word are streamed LSB-first through the gate, one bit per cycle. The
//   gate outputs are collected into a W-bit result, which is returned on a
//   valid/ready response channel tagged with the owning requester id.
//   Arbitration is round-robin; requester 0 wins the first tie after reset.
//
// Ports
//   clk          in   1   clock, all state changes on the rising edge
//   rst          in   1   synchronous active-high reset
//   req0_valid   in   1   requester 0 has a word pending
//   req0_ready   out  1   requester 0 word accepted this cycle
//   req0_data    in   W   requester 0 data word
//   req0_ctrl    in   W   requester 0 control word (1 = invert that bit)
//   req1_valid   in   1   requester 1 has a word pending
//   req1_ready   out  1   requester 1 word accepted this cycle
//   req1_data    in   W   requester 1 data word
//   req1_ctrl    in   W   requester 1 control word
//   gate_a       out  1   data bit driven to the shared gate
//   gate_en      out  1   control bit driven to the shared gate
//   gate_y       in   1   gate result, combinational from gate_a/gate_en
//   rsp_valid    out  1   assembled result available
//   rsp_ready    in   1   consumer takes the result on rsp_valid & rsp_ready
//   rsp_data     out  W   assembled result
//   rsp_id       out  1   requester that owns rsp_data
//   busy         out  1   high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module cnot_gate_scheduler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_data,
    input  logic [W-1:0] req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_data,
    input  logic [W-1:0] req1_ctrl,
    output logic         gate_a,
    output logic         gate_en,
    input  logic         gate_y,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);

    // Bit index is at least one bit wide so that W=1 still has a legal vector.
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_last_grant;
    logic [BW-1:0]  r_bit_idx;
    logic [W-1:0]   r_data;
    logic [W-1:0]   r_ctrl;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_id;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_accept;
    logic           w_last_bit;
    logic           w_bit_a;
    logic           w_bit_en;

    assign w_accept   = w_grant0 | w_grant1;
    assign w_last_bit = (r_bit_idx == BW'(W - 1));

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign busy       = (r_state != S_IDLE);

    // Select the current bit of the latched job. A compare-per-bit mux keeps
    // the index width independent of W (no out-of-range select for odd W).
    always_comb begin
        w_bit_a  = 1'b0;
        w_bit_en = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (r_bit_idx == BW'(i)) begin
                w_bit_a  = r_data[i];
                w_bit_en = r_ctrl[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant and gate/response strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        gate_a      = 1'b0;
        gate_en     = 1'b0;
        rsp_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Grants are suppressed while rst is high so that no
                // handshake is ever shown for a word that reset discards.
                if (!rst) begin
                    // On a tie the requester that did not win last time goes.
                    w_grant0 = req0_valid & (~req1_valid | r_last_grant);
                    w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
                end
                if (w_grant0 | w_grant1) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                gate_a  = w_bit_a;
                gate_en = w_bit_en;
                if (w_last_bit) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_bit_idx    <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant1;
                r_rsp_id     <= w_grant1;
                r_bit_idx    <= '0;
            end else if (r_state == S_RUN && !w_last_bit) begin
                r_bit_idx <= r_bit_idx + BW'(1);
            end

            // Gate result is sampled in the same cycle its operands are driven.
            if (r_state == S_RUN) begin
                for (int i = 0; i < W; i++) begin
                    if (r_bit_idx == BW'(i)) begin
                        r_rsp_data[i] <= gate_y;
                    end
                end
            end
        end
    end

    // Job operand latch; snapshot at grant so requesters may change their
    // inputs while the job is in flight.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= w_grant1 ? req1_data : req0_data;
            r_ctrl <= w_grant1 ? req1_ctrl : req0_ctrl;
        end
    end

endmodule

// File: tb/tb_cnot_gate_scheduler.sv
module tb_cnot_gate_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // W=8 instance signals
    logic       r0v, r0r, r1v, r1r;
    logic [7:0] r0d, r0c, r1d, r1c;
    logic       ga8, ge8, gy8, rv8, rr8, rid8, busy8;
    logic [7:0] rd8;

    // W=1 instance signals
    logic       q0v, q0r, q1v, q1r;
    logic [0:0] q0d, q0c, q1d, q1c;
    logic       ga1, ge1, gy1, rv1, rr1, rid1, busy1;
    logic [0:0] rd1;

    // Well-behaved shared gates
    assign gy8 = ge8 ? ~ga8 : ga8;
    assign gy1 = ge1 ? ~ga1 : ga1;

    cnot_gate_scheduler #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0r), .req0_data(r0d), .req0_ctrl(r0c),
        .req1_valid(r1v), .req1_ready(r1r), .req1_data(r1d), .req1_ctrl(r1c),
        .gate_a(ga8), .gate_en(ge8), .gate_y(gy8),
        .rsp_valid(rv8), .rsp_ready(rr8), .rsp_data(rd8), .rsp_id(rid8),
        .busy(busy8)
    );

    cnot_gate_scheduler #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(q0v), .req0_ready(q0r), .req0_data(q0d), .req0_ctrl(q0c),
        .req1_valid(q1v), .req1_ready(q1r), .req1_data(q1d), .req1_ctrl(q1c),
        .gate_a(ga1), .gate_en(ge1), .gate_y(gy1),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_data(rd1), .rsp_id(rid1),
        .busy(busy1)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboards: {id, data}
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop an expected response on every handshake
    logic [8:0] e8;
    always @(negedge clk) begin
        if (!rst && rv8 && rr8) begin
            if (q8.size() == 0) begin
                chk("rsp8_unexpected", {rid8, rd8}, 32'h1ff);
            end else begin
                e8 = q8.pop_front();
                chk("rsp8_id", rid8, e8[8]);
                chk("rsp8_data", rd8, e8[7:0]);
            end
        end
    end

    logic [1:0] e1;
    always @(negedge clk) begin
        if (!rst && rv1 && rr1) begin
            if (q1.size() == 0) begin
                chk("rsp1_unexpected", {rid1, rd1}, 32'h3);
            end else begin
                e1 = q1.pop_front();
                chk("rsp1_id", rid1, e1[1]);
                chk("rsp1_data", rd1, e1[0]);
            end
        end
    end

    // Wait for a ready strobe; returns at posedge+1 after the accepting edge
    task automatic wait_rdy(input int dut, input int id, input string name, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (dut == 0) seen = (id == 0) ? r0r : r1r;
            else          seen = (id == 0) ? q0r : q1r;
            if (seen) cyc = cyc_cnt;
        end
        chk({name, "_accept"}, seen, 1);
        @(posedge clk);
        #1;
    endtask

    // Wait for rsp_valid; returns at that negedge
    task automatic wait_rspv(input int dut, input string name, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = (dut == 0) ? rv8 : rv1;
            if (seen) cyc = cyc_cnt;
        end
        chk({name, "_rsp_seen"}, seen, 1);
    endtask

    task automatic wait_idle(input int dut, input string name);
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 60 && !idle; n++) begin
            @(negedge clk);
            idle = (dut == 0) ? !busy8 : !busy1;
        end
        chk({name, "_idle"}, idle, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, rc, a0, a1;
        logic [7:0] sa, se;
        logic [1:0] g;

        rst = 1'b1;
        r0v = 0; r1v = 0; r0d = 0; r0c = 0; r1d = 0; r1c = 0; rr8 = 1'b1;
        q0v = 0; q1v = 0; q0d = 0; q0c = 0; q1d = 0; q1c = 0; rr1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dut8", {r0r, r1r, ga8, ge8, rv8, rid8, busy8, rd8}, 0);
        chk("reset_dut1", {q0r, q1r, ga1, ge1, rv1, rid1, busy1, rd1}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: single job, gate bit sequence and latency
        q8.push_back({1'b0, 8'hAA});
        r0v = 1; r0d = 8'hA5; r0c = 8'h0F;
        wait_rdy(0, 0, "t1", acc);
        r0v = 0; r0d = 8'h00; r0c = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sa[i] = ga8;
            se[i] = ge8;
        end
        chk("t1_gate_a_seq", sa, 8'hA5);
        chk("t1_gate_en_seq", se, 8'h0F);
        wait_rspv(0, "t1", rc);
        chk("t1_latency", rc - acc, 9);
        wait_idle(0, "t1");

        // T2: simultaneous requests after reset -> 0 then 1, W+2 apart
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q8.push_back({1'b0, 8'hC3});
        q8.push_back({1'b1, 8'h13});
        r0v = 1; r0d = 8'h3C; r0c = 8'hFF;
        r1v = 1; r1d = 8'h12; r1c = 8'h01;
        @(negedge clk);
        chk("t2_first_grant", {r0r, r1r}, 2'b10);
        a0 = cyc_cnt;
        @(posedge clk); #1;
        r0v = 0;
        wait_rdy(0, 1, "t2_r1", a1);
        r1v = 0;
        chk("t2_interval", a1 - a0, 10);
        wait_idle(0, "t2");

        // T3: both held valid for four jobs -> grants alternate
        q8.push_back({1'b0, 8'h11});
        q8.push_back({1'b1, 8'h22});
        q8.push_back({1'b0, 8'hFF});
        q8.push_back({1'b1, 8'hAA});
        r0v = 1; r0d = 8'h01; r0c = 8'h10;
        r1v = 1; r1d = 8'h02; r1c = 8'h20;
        for (int j = 0; j < 4; j++) begin
            g = 2'b00;
            for (int n = 0; n < 40 && g == 2'b00; n++) begin
                @(negedge clk);
                g = {r0r, r1r};
            end
            chk($sformatf("t3_grant%0d", j), g, (j % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            if (j == 0) begin r0d = 8'hF0; r0c = 8'h0F; end
            if (j == 1) begin r1d = 8'h55; r1c = 8'hFF; end
            if (j == 3) begin r0v = 0; r1v = 0; end
        end
        wait_idle(0, "t3");

        // T4: consumer back-pressure in RESP
        rr8 = 1'b0;
        q8.push_back({1'b0, 8'h99});
        r0v = 1; r0d = 8'hC3; r0c = 8'h5A;
        wait_rdy(0, 0, "t4", acc);
        r0v = 0;
        r1v = 1; r1d = 8'h77; r1c = 8'h00;
        wait_rspv(0, "t4", rc);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("t4_hold%0d", i), {rv8, rid8, rd8, r0r, r1r},
                {1'b1, 1'b0, 8'h99, 1'b0, 1'b0});
        end
        @(posedge clk); #1;
        rr8 = 1'b1;
        q8.push_back({1'b1, 8'h77});
        @(negedge clk);
        @(negedge clk);
        chk("t4_idle_next", {busy8, r1r}, 2'b01);
        @(posedge clk); #1;
        r1v = 0;
        wait_idle(0, "t4");

        // T5: reset during RUN at bit 3 abandons the job
        r0v = 1; r0d = 8'hFF; r0c = 8'h00;
        wait_rdy(0, 0, "t5", acc);
        r0v = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        r0v = 1; r0d = 8'h0F; r0c = 8'h0F;
        r1v = 1; r1d = 8'h11; r1c = 8'h22;
        q8.push_back({1'b0, 8'h00});
        q8.push_back({1'b1, 8'h33});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_after_reset", {busy8, ge8, ga8, rv8, rd8, rid8, r0r, r1r},
            {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        r0v = 0;
        wait_rdy(0, 1, "t5_r1", a1);
        r1v = 0;
        wait_idle(0, "t5");

        // T6: W=1 instance
        q1.push_back({1'b0, 1'b0});
        q0v = 1; q0d = 1'b1; q0c = 1'b1;
        wait_rdy(1, 0, "t6a", acc);
        q0v = 0;
        wait_rspv(1, "t6a", rc);
        chk("t6_latency", rc - acc, 2);
        wait_idle(1, "t6a");

        q1.push_back({1'b0, 1'b1});
        q0v = 1; q0d = 1'b1; q0c = 1'b0;
        wait_rdy(1, 0, "t6b", acc);
        q0v = 0;
        wait_idle(1, "t6b");

        q1.push_back({1'b1, 1'b1});
        q1v = 1; q1d = 1'b0; q1c = 1'b1;
        wait_rdy(1, 1, "t6c", acc);
        q1v = 0;
        wait_idle(1, "t6c");

        repeat (3) @(negedge clk);
        chk("sb8_drained", q8.size(), 0);
        chk("sb1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
